sram_addr_decode_mux: RTL and testbench

- Address-decode and read-select slice of the 16x8 bit-addressable SRAM.
- Splits a 7-bit bit address into a row field and a column field.
- Produces one-hot row and column select vectors for the array and write driver.
- Selects one bit of the addressed 8-bit row word and presents it on a registered, single-cycle-latency read output.

---
 rtl/sram_addr_decode_mux.sv | 58 +++++
 tb/tb_sram_addr_decode_mux.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/sram_addr_decode_mux.sv
// Address decode and read-select slice of the bit-addressable SRAM.
// Splits a bit address into row/column fields, produces one-hot selects,
// and registers the selected bit of the addressed row word.
module sram_addr_decode_mux #(
  parameter int unsigned ROW_AW = 4,
  parameter int unsigned COL_AW = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         dec_en,
  input  logic [ROW_AW+COL_AW-1:0]     addr,
  input  logic [(1 << COL_AW)-1:0]     row_word,
  output logic [(1 << ROW_AW)-1:0]     row_sel,
  output logic [(1 << COL_AW)-1:0]     col_sel,
  output logic                         mux_out,
  output logic                         dout
);

  localparam int unsigned AW   = ROW_AW + COL_AW;
  localparam int unsigned NROW = 1 << ROW_AW;
  localparam int unsigned NCOL = 1 << COL_AW;

  logic [ROW_AW-1:0] row_idx;
  logic [COL_AW-1:0] col_idx;
  logic              dout_d;
  logic              dout_q;

  assign row_idx = addr[AW-1:COL_AW];
  assign col_idx = addr[COL_AW-1:0];

  // One-hot row and column decoders, gated by the decoder enable.
  always_comb begin
    row_sel = '0;
    col_sel = '0;
    if (dec_en) begin
      row_sel = NROW'(1) << row_idx;
      col_sel = NCOL'(1) << col_idx;
    end
  end

  // Read path: bit select of the row word, always active regardless of dec_en.
  always_comb begin
    mux_out = row_word[col_idx];
    dout_d  = mux_out;
  end

  // Read-bit register: one-cycle latency, updates every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_sram_addr_decode_mux.sv
// Self-checking bench for sram_addr_decode_mux: table vectors, hand sequences
// for reset/latency corners, and randomized stimulus against a reference model.
module tb_sram_addr_decode_mux;

  logic        clk;
  logic        rst_n;
  logic        dec_en;
  logic [6:0]  addr;
  logic [7:0]  row_word;
  logic [15:0] row_sel;
  logic [7:0]  col_sel;
  logic        mux_out;
  logic        dout;

  int n_chk  = 0;
  int n_fail = 0;

  bit   exp_dout_vld = 1'b0;
  logic exp_dout     = 1'b0;

  sram_addr_decode_mux #(.ROW_AW(4), .COL_AW(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dec_en   (dec_en),
    .addr     (addr),
    .row_word (row_word),
    .row_sel  (row_sel),
    .col_sel  (col_sel),
    .mux_out  (mux_out),
    .dout     (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          en;
    logic [6:0]  a;
    logic [7:0]  w;
    logic [15:0] er;
    logic [7:0]  ec;
    logic        em;
  } vec_t;

  vec_t vt[14];

  // Reference model: plain arithmetic on the row/column fields.
  function automatic logic [15:0] m_row(input bit en, input int a);
    return en ? 16'(2 ** (a / 8)) : 16'h0000;
  endfunction

  function automatic logic [7:0] m_col(input bit en, input int a);
    return en ? 8'(2 ** (a % 8)) : 8'h00;
  endfunction

  function automatic logic m_mux(input int w, input int a);
    return 1'((w / (2 ** (a % 8))) % 2);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One cycle: check the registered bit from the previous cycle, apply new
  // inputs, check the combinational outputs, and record the next dout.
  task automatic drive(input bit rst, input bit en, input logic [6:0] a, input logic [7:0] w);
    @(negedge clk);
    if (exp_dout_vld) chk("dout_lag", 32'(dout), 32'(exp_dout));
    rst_n    = rst;
    dec_en   = en;
    addr     = a;
    row_word = w;
    #1;
    chk("row_sel", 32'(row_sel), 32'(m_row(en, int'(a))));
    chk("col_sel", 32'(col_sel), 32'(m_col(en, int'(a))));
    chk("mux_out", 32'(mux_out), 32'(m_mux(int'(w), int'(a))));
    exp_dout     = rst ? m_mux(int'(w), int'(a)) : 1'b0;
    exp_dout_vld = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_b2b;
    rst_n    = 1'b0;
    dec_en   = 1'b0;
    addr     = '0;
    row_word = '0;

    vt[0]  = '{1'b1, 7'h5D, 8'hFF, 16'h0800, 8'h20, 1'b1};
    vt[1]  = '{1'b0, 7'h5D, 8'h20, 16'h0000, 8'h00, 1'b1};
    vt[2]  = '{1'b0, 7'h5D, 8'hDF, 16'h0000, 8'h00, 1'b0};
    vt[3]  = '{1'b1, 7'h00, 8'h81, 16'h0001, 8'h01, 1'b1};
    vt[4]  = '{1'b1, 7'h7F, 8'h81, 16'h8000, 8'h80, 1'b1};
    vt[5]  = '{1'b1, 7'h00, 8'hA5, 16'h0001, 8'h01, 1'b1};
    vt[6]  = '{1'b1, 7'h01, 8'hA5, 16'h0001, 8'h02, 1'b0};
    vt[7]  = '{1'b1, 7'h02, 8'hA5, 16'h0001, 8'h04, 1'b1};
    vt[8]  = '{1'b1, 7'h03, 8'hA5, 16'h0001, 8'h08, 1'b0};
    vt[9]  = '{1'b1, 7'h04, 8'hA5, 16'h0001, 8'h10, 1'b0};
    vt[10] = '{1'b1, 7'h05, 8'hA5, 16'h0001, 8'h20, 1'b1};
    vt[11] = '{1'b1, 7'h06, 8'hA5, 16'h0001, 8'h40, 1'b0};
    vt[12] = '{1'b1, 7'h07, 8'hA5, 16'h0001, 8'h80, 1'b1};
    vt[13] = '{1'b1, 7'h3A, 8'h00, 16'h0080, 8'h04, 1'b0};

    // Reset holds dout low while the read path still selects.
    drive(1'b0, 1'b1, 7'h5D, 8'hFF);
    @(posedge clk); #1;
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_mux", 32'(mux_out), 32'd1);
    drive(1'b1, 1'b1, 7'h5D, 8'hFF);
    @(posedge clk); #1;
    chk("rst_release_dout", 32'(dout), 32'd1);

    // Decode sweep with one-hot checks.
    for (int i = 0; i < 128; i++) begin
      drive(1'b1, 1'b1, 7'(i), 8'(i * 37));
      chk("row_onehot", 32'($onehot(row_sel)), 32'd1);
      chk("col_onehot", 32'($onehot(col_sel)), 32'd1);
    end

    // Table vectors against hand-derived constants.
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, vt[i].en, vt[i].a, vt[i].w);
      chk("vec_row_sel", 32'(row_sel), 32'(vt[i].er));
      chk("vec_col_sel", 32'(col_sel), 32'(vt[i].ec));
      chk("vec_mux_out", 32'(mux_out), 32'(vt[i].em));
    end

    // Back-to-back address changes: dout lags by exactly one edge.
    exp_b2b = 4'b1100;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b1, 7'((c * 3 + 1) * 8 + c), 8'h3C);
      chk("b2b_mux", 32'(mux_out), 32'(exp_b2b[c]));
      @(posedge clk); #1;
      chk("b2b_dout", 32'(dout), 32'(exp_b2b[c]));
    end

    // Randomized stimulus, including occasional reset pulses.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(15) != 0), 1'($urandom), 7'($urandom), 8'($urandom));
    end

    @(negedge clk);
    chk("dout_final", 32'(dout), 32'(exp_dout));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
